ir_fetch_ctrl: RTL
==================

# ir_fetch_ctrl

Instruction-fetch sequencer on the initiator side of the instruction register interface. It keeps the program counter, requests an 18-bit word from instruction memory, and commands the instruction register with `wr_IR` to load the word and `re_IR` to read it out. It then captures the instruction and hands it to the decoder over a valid/ack handshake. It sits between instruction memory, the instruction register and the decode/control unit of the processor.

## Interface
Parameters:
- `ADDR_W`, 10: program counter and memory address width.
- `INSTR_W`, 18: instruction width. Matches the instruction register.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`, input, 1: single clock. All logic updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `run`, input, 1: start fetching. Sampled only in IDLE.
- `mem_rd`, output, 1: instruction memory read request.
- `mem_addr`, output, ADDR_W: fetch address. Always equals `pc`.
- `mem_rdy`, input, 1: memory has the word on the IR input bus. The word must stay valid for the following cycle.
- `wr_IR`, output, 1: load command to the instruction register.
- `re_IR`, output, 1: read-out command to the instruction register.
- `IRout`, input, INSTR_W: instruction register output.
- `instr`, output, INSTR_W: captured instruction to the decoder.
- `instr_pc`, output, ADDR_W: address of `instr`.
- `instr_valid`, output, 1: `instr` is presented.
- `instr_ack`, input, 1: decoder accepts `instr`. Only meaningful while `instr_valid` is high.
- `pc_load`, input, 1: redirect. Sampled only together with an accepted ack.
- `pc_target`, input, ADDR_W: redirect target.
- `halt`, input, 1: stop after this instruction. Sampled only together with an accepted ack.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- The state machine has six states: IDLE, REQ, LOAD, READ, CAPT, PRESENT.
- IDLE: all strobes are low. If `run`=1, go to REQ.
- REQ: `mem_rd`=1. If `mem_rdy`=1, go to LOAD; otherwise stay, with no timeout.
- LOAD: `mem_rd`=1 and `wr_IR`=1 for exactly one cycle. Go to READ.
- READ: `re_IR`=1 for exactly one cycle. Go to CAPT.
- CAPT: `instr` <= `IRout`, `instr_pc` <= `pc`, `pc` <= `pc`+1. Go to PRESENT.
- PRESENT: `instr_valid`=1, and `instr`/`instr_pc` are held stable. When `instr_ack`=1:
  - if `halt`=1, go to IDLE;
  - otherwise go to REQ;
  - if `pc_load`=1, `pc` <= `pc_target`; otherwise `pc` is unchanged, since it was already incremented in CAPT.
- `halt` and `pc_load` may be high together. In that case both take effect: the PC is redirected and the FSM goes to IDLE.
- `wr_IR` and `re_IR` are never high in the same cycle. They are also never high outside LOAD and READ respectively.
- The PC increment is modulo 2^ADDR_W: the last address (all ones) wraps to 0.
- Inputs `run`, `mem_rdy`, `instr_ack`, `halt`, `pc_load` and `pc_target` are ignored in states other than those listed above.

## Timing
- Reset values: state=IDLE, `pc`=RESET_PC, `mem_rd`=`wr_IR`=`re_IR`=`instr_valid`=`busy`=0, `instr`=0, `instr_pc`=0.
- Reset takes priority over every other event. Asserting `rst` in any state returns the FSM to IDLE at the next edge. No further strobes are issued. A partially fetched instruction is discarded.
- All outputs are registered or decoded directly from state, with no combinational path from inputs to outputs.
- The instruction register captures `IRin` at the edge ending LOAD. It drives `IRout` at the edge ending READ. `IRout` is sampled at the edge ending CAPT, which is the only cycle in which it is guaranteed valid rather than high-Z.
- Minimum fetch latency (`mem_rdy` already high on entering REQ): `instr_valid` rises 4 cycles after REQ is entered.
- From `run` sampled in IDLE to `instr_valid`: 5 cycles.
- Back-to-back throughput: an ack with no halt re-enters REQ next cycle, giving 5 cycles per instruction at zero memory wait. Each cycle of `mem_rdy` low adds one cycle.
- `instr_valid` drops in the cycle after the ack.

## Test plan
- Reset/idle:
  - Stimulus: `rst` for 2 cycles, then `run`=0 for 10 cycles.
  - Required: all outputs hold their reset values, `mem_addr`=0, `busy`=0.
- Single fetch, zero wait:
  - Stimulus: RESET_PC=0, `mem_rdy`=1, memory word 18'h2A5C5. Pulse `run`.
  - Required: `wr_IR` is a one-cycle pulse, then `re_IR` is a one-cycle pulse. `instr_valid` rises 5 cycles after `run` with `instr`=18'h2A5C5 and `instr_pc`=0.
  - Ack with `halt`=1. Required: IDLE, `pc`=1.
- Memory wait plus handshake stall:
  - Stimulus: `mem_rdy` held low for 3 REQ cycles, then `instr_ack` withheld for 4 cycles.
  - Required: `wr_IR` is delayed exactly 3 cycles. `instr` is stable for the whole stall. There is exactly one `wr_IR` pulse and one `re_IR` pulse per instruction.
- Redirect:
  - Stimulus: ack the instruction at PC 5 with `pc_load`=1, `pc_target`=10'h3F0.
  - Required: the next `mem_addr` is 10'h3F0, and the next `instr_pc` is 10'h3F0.
- Wrap-around:
  - Stimulus: ADDR_W=10, PC at 10'h3FF, free-running acks.
  - Required: `instr_pc` sequence is 3FF, 000, 001.
- Reset mid-fetch:
  - Stimulus: assert `rst` during LOAD, then again during PRESENT.
  - Required: IDLE at the next edge, no `re_IR` pulse follows, `instr_valid`=0, and `pc`=RESET_PC.

Source files
------------

// File: rtl/ir_fetch_ctrl.sv
// Instruction-fetch sequencer: PC, memory request, IR load/read strobes, decoder handoff.
// Latency 5 cycles run->instr_valid (+1 per mem_rdy-low REQ cycle); holds instr until instr_ack.
module ir_fetch_ctrl #(
    parameter int                ADDR_W   = 10,
    parameter int                INSTR_W  = 18,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_rdy,
    output logic               wr_IR,
    output logic               re_IR,
    input  logic [INSTR_W-1:0] IRout,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ack,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_target,
    input  logic               halt,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_READ,
        S_CAPT,
        S_PRESENT
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_REQ;
            end
            S_REQ: begin
                if (mem_rdy) state_d = S_LOAD;
            end
            S_LOAD: state_d = S_READ;
            S_READ: state_d = S_CAPT;
            S_CAPT: begin
                // IRout is only driven during this cycle; PC advances here so a redirect can override it later.
                instr_d    = IRout;
                instr_pc_d = pc_q;
                pc_d       = pc_q + ADDR_W'(1);
                state_d    = S_PRESENT;
            end
            S_PRESENT: begin
                if (instr_ack) begin
                    state_d = halt ? S_IDLE : S_REQ;
                    if (pc_load) pc_d = pc_target;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Strobes are pure state decodes, so no input reaches an output combinationally.
    assign mem_rd      = (state_q == S_REQ) || (state_q == S_LOAD);
    assign wr_IR       = (state_q == S_LOAD);
    assign re_IR       = (state_q == S_READ);
    assign instr_valid = (state_q == S_PRESENT);
    assign busy        = (state_q != S_IDLE);
    assign mem_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule
